// File: rtl/any1_pkg.sv
// Shared ANY-1 types: data-bus sequencer states, timeout default, lane-mask helper.
package any1_pkg;

  typedef enum logic [2:0] {IDLE, P1, GAP, P2, DONE} DbusState;

  localparam int DBUS_TMO_DEFAULT = 8;

  // Expand a byte-lane select into a 64-bit bit mask.
  function automatic logic [63:0] lane_mask(input logic [7:0] sel);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/any1_lane_shift.sv
// Combinational byte-lane shifter: widens sel/dat to 16/128 bits and shifts left by ofs bytes.
module any1_lane_shift (
  input  logic [7:0]   sel,
  input  logic [63:0]  dat,
  input  logic [2:0]   ofs,
  output logic [15:0]  mask,
  output logic [127:0] data
);

  assign mask = {8'h00, sel} << ofs;
  assign data = {64'h0, dat} << {ofs, 3'b000};

endmodule

// File: rtl/any1_dbus_align.sv
// ANY-1 data-bus sequencer: aligns byte lanes to the 64-bit bus and runs one or two
// locked Wishbone-classic cycles, returning right-aligned zero-extended load data.
module any1_dbus_align
  import any1_pkg::*;
#(
  parameter int AWID     = 32,
  parameter int TMO_BITS = DBUS_TMO_DEFAULT
) (
  input  logic            rst_i,
  input  logic            clk_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [AWID-1:0] adr_i,
  input  logic [7:0]      sel_i,
  input  logic [63:0]     dat_i,
  output logic            rdy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [63:0]     res_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [7:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [63:0]     dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [63:0]     bdat_i
);

  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'((2**TMO_BITS) - 2);

  DbusState state, state_nxt;

  logic [2:0]          ofs_q;
  logic [7:0]          sel_q;
  logic [7:0]          sel2_q;
  logic [63:0]         dat2_q;
  logic                split_q;
  logic [TMO_BITS-1:0] tmo_cnt;

  logic [7:0]   sh_sel;
  logic [63:0]  sh_dat;
  logic [2:0]   sh_ofs;
  logic [15:0]  sh_mask;
  logic [127:0] sh_data;

  logic        in_bus;
  logic        tmo_hit;
  logic        fail;
  logic [63:0] w1_term;

  // One shifter serves both directions: in IDLE it positions store data and
  // lanes; during bus phases a left shift by (8-ofs) bytes reassembles the
  // load word, upper half being w1>>8*ofs and lower half w2<<(64-8*ofs).
  always_comb begin
    sh_sel = sel_q;
    sh_dat = bdat_i;
    sh_ofs = 3'd0 - ofs_q;
    if (state == IDLE) begin
      sh_sel = sel_i;
      sh_dat = dat_i;
      sh_ofs = adr_i[2:0];
    end
  end

  any1_lane_shift u_shift (
    .sel  (sh_sel),
    .dat  (sh_dat),
    .ofs  (sh_ofs),
    .mask (sh_mask),
    .data (sh_data)
  );

  assign in_bus  = (state == P1) || (state == P2);
  assign tmo_hit = in_bus && !ack_i && (tmo_cnt == TMO_LAST);
  assign fail    = in_bus && (err_i || tmo_hit);
  assign w1_term = (ofs_q == 3'd0) ? sh_data[63:0] : sh_data[127:64];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_i) state_nxt = (sel_i == 8'h00) ? DONE : P1;
      P1: begin
        if (fail)       state_nxt = DONE;
        else if (ack_i) state_nxt = split_q ? GAP : DONE;
      end
      GAP:  state_nxt = P2;
      P2:   if (fail || ack_i) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy_o  = (state == IDLE);
    cyc_o  = (state == P1) || (state == GAP) || (state == P2);
    stb_o  = in_bus;
    done_o = (state == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ofs_q   <= '0;
      sel_q   <= '0;
      sel2_q  <= '0;
      dat2_q  <= '0;
      split_q <= 1'b0;
      tmo_cnt <= '0;
      we_o    <= 1'b0;
      sel_o   <= '0;
      adr_o   <= '0;
      dat_o   <= '0;
      err_o   <= 1'b0;
      res_o   <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          ofs_q   <= adr_i[2:0];
          sel_q   <= sel_i;
          sel2_q  <= sh_mask[15:8];
          split_q <= |sh_mask[15:8];
          dat2_q  <= sh_data[127:64];
          adr_o   <= {adr_i[AWID-1:3], 3'b000};
          sel_o   <= sh_mask[7:0];
          dat_o   <= sh_data[63:0];
          we_o    <= we_i;
          err_o   <= 1'b0;
          res_o   <= '0;
          tmo_cnt <= '0;
        end
        P1, P2: begin
          if (fail) begin
            err_o <= 1'b1;
            res_o <= '0;
          end else if (ack_i) begin
            if (state == P1) res_o <= w1_term & lane_mask(sel_q);
            else             res_o <= (res_o | sh_data[63:0]) & lane_mask(sel_q);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GAP: begin
          adr_o   <= adr_o + AWID'(8);
          sel_o   <= sel2_q;
          dat_o   <= dat2_q;
          tmo_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
